// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU port, loader port and RAM-side signals.
// slave = arbiter side, master = requesters and RAM model side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    // CPU port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;
    // loader/debug port
    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_ack;
    // RAM side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        output ldr_rdata, ldr_ack,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        input  ldr_rdata, ldr_ack,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter + wait-state sequencer for the main RAM.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave):
//   cpu_* / ldr_* request ports, mem_* RAM side, busy.
module mem_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            state;
    logic              last_gnt;  // 1 = loader won last grant
    logic              owner;     // 1 = loader owns current access
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              cpu_ack;
    logic              ldr_ack;
    logic              pick_ldr;

    // Loader wins if alone, or on a tie when the CPU had the last grant.
    assign pick_ldr = bus.ldr_req & (~bus.cpu_req | ~last_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            owner     <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.ldr_req) begin
                        owner    <= pick_ldr;
                        last_gnt <= pick_ldr;
                        cnt      <= CNT_INIT;
                        state    <= ACCESS;
                        if (pick_ldr) begin
                            mem_addr  <= bus.ldr_addr;
                            mem_wdata <= bus.ldr_wdata;
                            mem_we    <= bus.ldr_we;
                            mem_re    <= ~bus.ldr_we;
                        end else begin
                            mem_addr  <= bus.cpu_addr;
                            mem_wdata <= bus.cpu_wdata;
                            mem_we    <= bus.cpu_we;
                            mem_re    <= ~bus.cpu_we;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // last access cycle: RAM data is valid now
                        if (mem_re) begin
                            if (owner) ldr_rdata <= bus.mem_rdata;
                            else       cpu_rdata <= bus.mem_rdata;
                        end
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                        state  <= DONE;
                        if (owner) ldr_ack <= 1'b1;
                        else       cpu_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_we    = mem_we;
    assign bus.mem_re    = mem_re;
    assign bus.cpu_rdata = cpu_rdata;
    assign bus.ldr_rdata = ldr_rdata;
    assign bus.cpu_ack   = cpu_ack;
    assign bus.ldr_ack   = ldr_ack;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
    assign bus.busy      = (state != IDLE);

endmodule
